// File: rtl/alarm_clock_multi.sv
// 24-hour BCD timekeeping core with NUM_ALARMS alarms, snooze and ring timeout.
// Hours and minutes are held as BCD digits; seconds are held in binary.
module alarm_clock_multi #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            hour_in1,
    input  logic [3:0]            hour_in0,
    input  logic [2:0]            minute_in1,
    input  logic [3:0]            minute_in0,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic [1:0]            hour_out1,
    output logic [3:0]            hour_out0,
    output logic [2:0]            minute_out1,
    output logic [3:0]            minute_out0,
    output logic [5:0]            seconds,
    output logic                  tick_1hz,
    output logic                  ringing,
    output logic [AW-1:0]         ring_src,
    output logic                  sound,
    output logic                  load_err
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [11:0]   SNZ_LOAD   = 12'(SNOOZE_MIN * 60);
    localparam logic [7:0]    RING_LIM   = 8'(RING_TIMEOUT_S);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    function automatic logic time_valid(input logic [1:0] h1, input logic [3:0] h0,
                                        input logic [2:0] m1, input logic [3:0] m0);
        return (h0 <= 4'd9) && (m1 <= 3'd5) && (m0 <= 4'd9) &&
               ((h1 < 2'd2) || ((h1 == 2'd2) && (h0 <= 4'd3)));
    endfunction

    logic [PW-1:0]  presc_q, presc_d;
    logic [5:0]     sec_q, sec_d;
    logic [1:0]     h1_q, h1_d;
    logic [3:0]     h0_q, h0_d;
    logic [2:0]     m1_q, m1_d;
    logic [3:0]     m0_q, m0_d;
    logic [12:0]    alarm_q [NUM_ALARMS];
    logic [12:0]    alarm_d [NUM_ALARMS];
    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  ring_src_q, ring_src_d;
    logic [7:0]     ring_cnt_q, ring_cnt_d;
    logic [11:0]    snz_cnt_q, snz_cnt_d;
    logic           lt_prev_q, la_prev_q, st_prev_q, sz_prev_q;
    logic           tick_q, ringing_q, sound_q, load_err_q;
    logic           tick_d, ringing_d, sound_d, load_err_d;

    logic           lt_edge_s, la_edge_s, st_edge_s, sz_edge_s;
    logic           in_ok_s, sel_ok_s, do_lt_s, do_la_s, tick_s, minute_roll_s;
    logic           match_s, en_src_s;
    logic [AW-1:0]  match_idx_s;
    logic [12:0]    in_hhmm_s, new_hhmm_s;

    // Edge detection, load validation and the prescaler/time-of-day counters
    always_comb begin
        lt_edge_s  = load_time  & ~lt_prev_q;
        la_edge_s  = load_alarm & ~la_prev_q;
        st_edge_s  = stop_alarm & ~st_prev_q;
        sz_edge_s  = snooze     & ~sz_prev_q;
        in_hhmm_s  = {hour_in1, hour_in0, minute_in1, minute_in0};
        in_ok_s    = time_valid(hour_in1, hour_in0, minute_in1, minute_in0);
        sel_ok_s   = (int'(alarm_sel) < NUM_ALARMS);
        do_lt_s    = lt_edge_s & in_ok_s;
        do_la_s    = la_edge_s & in_ok_s & sel_ok_s;
        load_err_d = (lt_edge_s & ~in_ok_s) | (la_edge_s & ~(in_ok_s & sel_ok_s));
        // A time load swallows a coincident tick so the new time starts clean
        tick_s        = (presc_q == PRESC_MAX) & ~do_lt_s;
        minute_roll_s = tick_s & (sec_q == 6'd59);
        tick_d        = tick_s;

        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        sec_d = sec_q;
        h1_d  = h1_q;
        h0_d  = h0_q;
        m1_d  = m1_q;
        m0_d  = m0_q;
        if (do_lt_s) begin
            {h1_d, h0_d, m1_d, m0_d} = in_hhmm_s;
            sec_d   = 6'd0;
            presc_d = '0;
        end else if (tick_s) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (m0_q == 4'd9) begin
                    m0_d = 4'd0;
                    if (m1_q == 3'd5) begin
                        m1_d = 3'd0;
                        if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                            h1_d = 2'd0;
                            h0_d = 4'd0;
                        end else if (h0_q == 4'd9) begin
                            h0_d = 4'd0;
                            h1_d = h1_q + 2'd1;
                        end else begin
                            h0_d = h0_q + 4'd1;
                        end
                    end else begin
                        m1_d = m1_q + 3'd1;
                    end
                end else begin
                    m0_d = m0_q + 4'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            sec_d = sec_q;
        end
        new_hhmm_s = {h1_d, h0_d, m1_d, m0_d};
    end

    // Alarm register writes and lowest-index match search
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = '0;
        en_src_s    = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (do_la_s && (alarm_sel == AW'(i))) begin
                alarm_d[i] = in_hhmm_s;
            end else begin
                alarm_d[i] = alarm_q[i];
            end
            if (ring_src_q == AW'(i)) begin
                en_src_s = alarm_en[i];
            end else begin
                en_src_s = en_src_s;
            end
        end
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (minute_roll_s && alarm_en[i] && (alarm_q[i] == new_hhmm_s)) begin
                match_s     = 1'b1;
                match_idx_s = AW'(i);
            end else begin
                match_s     = match_s;
            end
        end
    end

    // Ring/snooze state machine; stop beats snooze, disabling the source alarm aborts
    always_comb begin
        state_d    = state_q;
        ring_src_d = ring_src_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (match_s) begin
                    state_d    = ST_RING;
                    ring_src_d = match_idx_s;
                    ring_cnt_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RING: begin
                if (st_edge_s || !en_src_s) begin
                    state_d = ST_IDLE;
                end else if (sz_edge_s) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                end else if (tick_s) begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    if (ring_cnt_d >= RING_LIM) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RING;
                    end
                end else begin
                    state_d = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (st_edge_s || !en_src_s) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    snz_cnt_d = snz_cnt_q - 12'd1;
                    if (snz_cnt_q <= 12'd1) begin
                        state_d    = ST_RING;
                        ring_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_SNOOZE;
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ringing_d = (state_d == ST_RING);
        sound_d   = ringing_d & (presc_d < PRESC_HALF);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            sec_q      <= 6'd0;
            h1_q       <= 2'd0;
            h0_q       <= 4'd0;
            m1_q       <= 3'd0;
            m0_q       <= 4'd0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= 13'd0;
            end
            state_q    <= ST_IDLE;
            ring_src_q <= '0;
            ring_cnt_q <= 8'd0;
            snz_cnt_q  <= 12'd0;
            lt_prev_q  <= 1'b0;
            la_prev_q  <= 1'b0;
            st_prev_q  <= 1'b0;
            sz_prev_q  <= 1'b0;
            tick_q     <= 1'b0;
            ringing_q  <= 1'b0;
            sound_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            h1_q       <= h1_d;
            h0_q       <= h0_d;
            m1_q       <= m1_d;
            m0_q       <= m0_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= alarm_d[i];
            end
            state_q    <= state_d;
            ring_src_q <= ring_src_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            lt_prev_q  <= load_time;
            la_prev_q  <= load_alarm;
            st_prev_q  <= stop_alarm;
            sz_prev_q  <= snooze;
            tick_q     <= tick_d;
            ringing_q  <= ringing_d;
            sound_q    <= sound_d;
            load_err_q <= load_err_d;
        end
    end

    assign hour_out1   = h1_q;
    assign hour_out0   = h0_q;
    assign minute_out1 = m1_q;
    assign minute_out0 = m0_q;
    assign seconds     = sec_q;
    assign tick_1hz    = tick_q;
    assign ringing     = ringing_q;
    assign ring_src    = ring_src_q;
    assign sound       = sound_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: load-validation vector table plus
// hand-written rollover, ring, snooze, timeout and reset sequences.
module tb_alarm_clock_multi;
    localparam int CLK_HZ = 10;
    localparam int NA     = 5;
    localparam int AW     = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    hour_in1;
    logic [3:0]    hour_in0;
    logic [2:0]    minute_in1;
    logic [3:0]    minute_in0;
    logic          load_time, load_alarm, stop_alarm, snooze;
    logic [AW-1:0] alarm_sel;
    logic [NA-1:0] alarm_en;
    logic [1:0]    hour_out1;
    logic [3:0]    hour_out0;
    logic [2:0]    minute_out1;
    logic [3:0]    minute_out0;
    logic [5:0]    seconds;
    logic          tick_1hz, ringing, sound, load_err;
    logic [AW-1:0] ring_src;
    logic [12:0]   now_hhmm;

    assign now_hhmm = {hour_out1, hour_out0, minute_out1, minute_out0};

    always #5 clk = ~clk;

    alarm_clock_multi #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)
    ) dut (
        .clk(clk), .reset(reset),
        .hour_in1(hour_in1), .hour_in0(hour_in0),
        .minute_in1(minute_in1), .minute_in0(minute_in0),
        .load_time(load_time), .load_alarm(load_alarm), .alarm_sel(alarm_sel),
        .alarm_en(alarm_en), .stop_alarm(stop_alarm), .snooze(snooze),
        .hour_out1(hour_out1), .hour_out0(hour_out0),
        .minute_out1(minute_out1), .minute_out0(minute_out0),
        .seconds(seconds), .tick_1hz(tick_1hz), .ringing(ringing),
        .ring_src(ring_src), .sound(sound), .load_err(load_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic       is_alarm;
        logic [2:0] sel;
        logic       err;
    } vec_t;
    vec_t vt[11];

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] act);
        sb_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", e.tag, act, e.exp);
            end
        end
    endtask

    function automatic logic [12:0] pk(input int h, input int m);
        logic [12:0] r;
        r = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
        return r;
    endfunction

    task automatic set_in(input logic [12:0] t);
        {hour_in1, hour_in0, minute_in1, minute_in0} = t;
    endtask

    // which: 0 load_time, 1 load_alarm, 2 stop, 3 snooze, 4 stop+snooze
    task automatic pulse(input int which);
        case (which)
            0: load_time  = 1'b1;
            1: load_alarm = 1'b1;
            2: stop_alarm = 1'b1;
            3: snooze     = 1'b1;
            default: begin stop_alarm = 1'b1; snooze = 1'b1; end
        endcase
        @(negedge clk);
        load_time  = 1'b0;
        load_alarm = 1'b0;
        stop_alarm = 1'b0;
        snooze     = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!tick_1hz && c < 2 * CLK_HZ + 2);
            if (!tick_1hz) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tick_timeout: got no tick in %0d cycles, required one every %0d", c, CLK_HZ);
                return;
            end
        end
    endtask

    task automatic load_time_to(input logic [12:0] t);
        set_in(t);
        pulse(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] model_hhmm;
        logic [9:0]  snd;
        int          c;
        logic [12:0] roll_from [3];
        logic [12:0] roll_to   [3];

        vt[0]  = '{2'd0, 4'd7,  3'd2, 4'd9,  1'b0, 3'd0, 1'b0};
        vt[1]  = '{2'd2, 4'd4,  3'd0, 4'd0,  1'b0, 3'd0, 1'b1};
        vt[2]  = '{2'd1, 4'd9,  3'd5, 4'd9,  1'b0, 3'd0, 1'b0};
        vt[3]  = '{2'd0, 4'd0,  3'd6, 4'd0,  1'b0, 3'd0, 1'b1};
        vt[4]  = '{2'd2, 4'd3,  3'd5, 4'd9,  1'b0, 3'd0, 1'b0};
        vt[5]  = '{2'd3, 4'd0,  3'd0, 4'd0,  1'b0, 3'd0, 1'b1};
        vt[6]  = '{2'd0, 4'd10, 3'd0, 4'd0,  1'b0, 3'd0, 1'b1};
        vt[7]  = '{2'd0, 4'd7,  3'd3, 4'd0,  1'b1, 3'd5, 1'b1};
        vt[8]  = '{2'd0, 4'd7,  3'd3, 4'd0,  1'b1, 3'd2, 1'b0};
        vt[9]  = '{2'd2, 4'd5,  3'd3, 4'd0,  1'b1, 3'd2, 1'b1};
        vt[10] = '{2'd1, 4'd2,  3'd3, 4'd4,  1'b0, 3'd0, 1'b0};

        reset = 1'b1;
        {hour_in1, hour_in0, minute_in1, minute_in0} = 13'd0;
        load_time = 1'b0; load_alarm = 1'b0; stop_alarm = 1'b0; snooze = 1'b0;
        alarm_sel = 3'd0; alarm_en = 5'd0;
        repeat (3) @(negedge clk);
        expect_val("reset hhmm", 32'd0);      check_next(32'(now_hhmm));
        expect_val("reset seconds", 32'd0);   check_next(32'(seconds));
        expect_val("reset ringing", 32'd0);   check_next(32'(ringing));
        expect_val("reset tick", 32'd0);      check_next(32'(tick_1hz));
        reset = 1'b0;

        // load validation table
        model_hhmm = 13'd0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_in({vt[i].h1, vt[i].h0, vt[i].m1, vt[i].m0});
            alarm_sel = vt[i].sel;
            if (!vt[i].is_alarm && !vt[i].err) model_hhmm = {vt[i].h1, vt[i].h0, vt[i].m1, vt[i].m0};
            expect_val($sformatf("vec%0d hhmm", i), 32'(model_hhmm));
            expect_val($sformatf("vec%0d load_err", i), 32'(vt[i].err));
            pulse(vt[i].is_alarm ? 1 : 0);
            check_next(32'(now_hhmm));
            check_next(32'(load_err));
            if (!vt[i].is_alarm && !vt[i].err) begin
                expect_val($sformatf("vec%0d seconds", i), 32'd0);
                check_next(32'(seconds));
            end
            @(negedge clk);
            expect_val($sformatf("vec%0d load_err clear", i), 32'd0);
            check_next(32'(load_err));
        end

        // day rollover and tick spacing
        load_time_to(pk(23, 59));
        wait_ticks(1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tick_1hz && c < 30);
        expect_val("tick period", 32'(CLK_HZ)); check_next(32'(c));
        wait_ticks(57);
        expect_val("23:59 hhmm", 32'(pk(23, 59)));  check_next(32'(now_hhmm));
        expect_val("23:59 seconds", 32'd59);        check_next(32'(seconds));
        wait_ticks(1);
        expect_val("midnight hhmm", 32'd0);         check_next(32'(now_hhmm));
        expect_val("midnight seconds", 32'd0);      check_next(32'(seconds));

        roll_from[0] = pk(9, 59);  roll_to[0] = pk(10, 0);
        roll_from[1] = pk(19, 59); roll_to[1] = pk(20, 0);
        roll_from[2] = pk(12, 9);  roll_to[2] = pk(12, 10);
        for (int i = 0; i < 3; i++) begin
            load_time_to(roll_from[i]);
            wait_ticks(60);
            expect_val($sformatf("carry%0d hhmm", i), 32'(roll_to[i]));
            check_next(32'(now_hhmm));
        end

        // alarm 2 fires, beep duty, snooze, then stop+snooze
        alarm_en = 5'b00100;
        load_time_to(pk(7, 29));
        wait_ticks(59);
        expect_val("pre-alarm ringing", 32'd0); check_next(32'(ringing));
        wait_ticks(1);
        expect_val("alarm2 ringing", 32'd1);    check_next(32'(ringing));
        expect_val("alarm2 ring_src", 32'd2);   check_next(32'(ring_src));
        expect_val("alarm2 hhmm", 32'(pk(7, 30))); check_next(32'(now_hhmm));
        for (int k = 0; k < 10; k++) begin
            snd[k] = sound;
            @(negedge clk);
        end
        expect_val("sound pattern", 32'h01F);   check_next(32'(snd));
        pulse(3);
        expect_val("snooze ringing", 32'd0);    check_next(32'(ringing));
        wait_ticks(299);
        expect_val("snooze 299", 32'd0);        check_next(32'(ringing));
        wait_ticks(1);
        expect_val("snooze expiry ringing", 32'd1); check_next(32'(ringing));
        expect_val("snooze expiry src", 32'd2);     check_next(32'(ring_src));
        pulse(4);
        expect_val("stop+snooze ringing", 32'd0); check_next(32'(ringing));
        wait_ticks(300);
        expect_val("stop+snooze stays idle", 32'd0); check_next(32'(ringing));

        // alarms 1 and 3 at 07:30: lowest index wins, timeout after 60 ticks
        set_in(pk(7, 30));
        alarm_sel = 3'd1; pulse(1);
        alarm_sel = 3'd3; pulse(1);
        alarm_en = 5'b01010;
        load_time_to(pk(7, 29));
        wait_ticks(60);
        expect_val("prio ringing", 32'd1);      check_next(32'(ringing));
        expect_val("prio ring_src", 32'd1);     check_next(32'(ring_src));
        wait_ticks(59);
        expect_val("timeout-1 ringing", 32'd1); check_next(32'(ringing));
        wait_ticks(1);
        expect_val("timeout ringing", 32'd0);   check_next(32'(ringing));

        // disabling the source alarm aborts ringing
        load_time_to(pk(7, 29));
        wait_ticks(60);
        expect_val("en-drop pre ringing", 32'd1); check_next(32'(ringing));
        alarm_en = 5'b01000;
        @(negedge clk);
        expect_val("en-drop ringing", 32'd0);   check_next(32'(ringing));
        expect_val("en-drop src held", 32'd1);  check_next(32'(ring_src));

        // async reset mid-ring clears outputs and alarms
        alarm_en = 5'b01010;
        load_time_to(pk(7, 29));
        wait_ticks(60);
        expect_val("pre-reset ringing", 32'd1); check_next(32'(ringing));
        #2 reset = 1'b1;
        #1;
        expect_val("async reset ringing", 32'd0); check_next(32'(ringing));
        expect_val("async reset hhmm", 32'd0);    check_next(32'(now_hhmm));
        expect_val("async reset src", 32'd0);     check_next(32'(ring_src));
        @(negedge clk);
        reset = 1'b0;
        alarm_en = 5'b00010;
        load_time_to(pk(23, 59));
        wait_ticks(60);
        expect_val("cleared alarm ringing", 32'd1); check_next(32'(ringing));
        expect_val("cleared alarm src", 32'd1);     check_next(32'(ring_src));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
